// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//
// RV32I + M execute stage. Single-cycle ALU operations are computed
// combinationally and registered into the EX/MEM pipeline register.
// M-extension operations (MUL*, DIV*, REM*) are run iteratively: one
// shift-add (multiply) or restoring-divide step per cycle on operand
// magnitudes, with the sign fixed up when the result is registered.
//
// Ports
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   keep                global stall: holds every register in this stage
//   nop                 flush: loads a bubble and aborts any M-op
//   *_in, op_a, op_b    decode-stage control, function codes and operands
//   rs2_in              store data, passed through as read_data2_pype2
//   imm_in, PC_in       branch/JALR immediate and instruction address
//   *_pype2, ALU_co_pype  registered outputs to the memory stage
//   md_busy             combinational stall request while an M-op runs
// -----------------------------------------------------------------------------
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        nop,
  input  logic        RegWrite_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic [1:0]  MemRW_in,
  input  logic [2:0]  MemBranch_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [6:0]  funct7_in,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] rs2_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] PC_in,
  input  logic [4:0]  WReg_in,
  input  logic [31:0] Instr_in,
  output logic        RegWrite_pype2,
  output logic [1:0]  MemtoReg_pype2,
  output logic [1:0]  MemRW_pype2,
  output logic [2:0]  MemBranch_pype2,
  output logic [2:0]  funct3_pype2,
  output logic [6:0]  opcode_pype2,
  output logic [1:0]  dsize_pype2,
  output logic [31:0] ALU_co_pype,
  output logic [31:0] read_data2_pype2,
  output logic [31:0] PCBranch_pype2,
  output logic [31:0] PCp4_pype2,
  output logic [4:0]  WReg_pype2,
  output logic [31:0] Instraction_pype2,
  output logic        md_busy
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // EX/MEM pipeline register; a bubble is simply all-zero.
  typedef struct packed {
    logic        reg_write;
    logic [1:0]  memto_reg;
    logic [1:0]  mem_rw;
    logic [2:0]  mem_branch;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic [1:0]  dsize;
    logic [31:0] alu_co;
    logic [31:0] read_data2;
    logic [31:0] pc_branch;
    logic [31:0] pc_p4;
    logic [4:0]  wreg;
    logic [31:0] instr;
  } ex_mem_t;

  ex_mem_t     out_q, out_d;

  logic [1:0]  md_state_q, md_state_d;
  logic [4:0]  md_cnt_q, md_cnt_d;
  logic [2:0]  md_op_q, md_op_d;     // funct3 of the running M-op
  logic        md_neg_q, md_neg_d;   // negate the final magnitude
  logic        md_dz_q, md_dz_d;     // signed DIV by zero
  logic [31:0] md_b_q, md_b_d;       // multiplicand / divisor magnitude
  logic [31:0] md_hi_q, md_hi_d;     // product high / partial remainder
  logic [31:0] md_lo_q, md_lo_d;     // multiplier / dividend -> quotient

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [4:0]  shamt;
  logic [31:0] add_res, sub_res, sll_res, srl_res, sra_res, jalr_target;
  logic        slt_s, slt_u;
  logic [31:0] alu_res;

  assign shamt       = op_b[4:0];
  assign add_res     = op_a + op_b;
  assign sub_res     = op_a - op_b;
  assign sll_res     = op_a << shamt;
  assign srl_res     = op_a >> shamt;
  // Kept as its own assignment so the signed operand is not turned unsigned
  // by a surrounding ternary, which would make >>> a logical shift.
  assign sra_res     = $signed(op_a) >>> shamt;
  assign slt_s       = $signed(op_a) < $signed(op_b);
  assign slt_u       = op_a < op_b;
  assign jalr_target = (op_a + imm_in) & 32'hFFFF_FFFE;

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    alu_res = '0;
    case (opcode_in)
      OPC_OP, OPC_OPIMM: begin
        case (funct3_in)
          3'b000:  alu_res = (opcode_in == OPC_OP && funct7_in[5]) ? sub_res : add_res;
          3'b001:  alu_res = sll_res;
          3'b010:  alu_res = {31'd0, slt_s};
          3'b011:  alu_res = {31'd0, slt_u};
          3'b100:  alu_res = op_a ^ op_b;
          3'b101:  alu_res = funct7_in[5] ? sra_res : srl_res;
          3'b110:  alu_res = op_a | op_b;
          3'b111:  alu_res = op_a & op_b;
          default: alu_res = '0;
        endcase
      end
      // AUIPC arrives with PC as op_a and the upper immediate as op_b.
      OPC_LOAD, OPC_STORE, OPC_AUIPC: alu_res = add_res;
      OPC_LUI:                        alu_res = op_b;
      OPC_BRANCH: begin
        case (funct3_in)
          3'b000, 3'b001: alu_res = sub_res;          // BEQ/BNE: zero test downstream
          3'b100, 3'b101: alu_res = {31'd0, slt_s};   // BLT/BGE
          3'b110, 3'b111: alu_res = {31'd0, slt_u};   // BLTU/BGEU
          default:        alu_res = '0;
        endcase
      end
      OPC_JALR: alu_res = jalr_target;
      default:  alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // M-extension datapath
  // ---------------------------------------------------------------------------
  logic        m_op;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign m_op     = (opcode_in == OPC_OP) && (funct7_in == F7_MULDIV);
  assign a_signed = (funct3_in == F3_MULH) || (funct3_in == F3_MULHSU) ||
                    (funct3_in == F3_DIV)  || (funct3_in == F3_REM);
  assign b_signed = (funct3_in == F3_MULH) || (funct3_in == F3_DIV) ||
                    (funct3_in == F3_REM);
  assign a_neg    = a_signed & op_a[31];
  assign b_neg    = b_signed & op_b[31];
  // The most negative value negates to itself, which is the right unsigned
  // magnitude; this also yields the 0x8000_0000 / -1 overflow result.
  assign a_mag    = a_neg ? (32'd0 - op_a) : op_a;
  assign b_mag    = b_neg ? (32'd0 - op_b) : op_b;

  // Shift-add step: {hi,lo} shifts right, adding the multiplicand into hi
  // whenever the multiplier bit leaving lo is set.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_b_q} : 33'd0);

  // Restoring-divide step: shift the next dividend bit into the remainder
  // and subtract the divisor when it fits; the borrow bit says it did not.
  logic [32:0] div_shift, div_diff;
  logic        div_fits;
  assign div_shift = {md_hi_q, md_lo_q[31]};
  assign div_diff  = div_shift - {1'b0, md_b_q};
  assign div_fits  = ~div_diff[32];

  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s, md_result;

  assign prod_s = md_neg_q ? (64'd0 - {md_hi_q, md_lo_q}) : {md_hi_q, md_lo_q};
  assign quot_s = md_neg_q ? (32'd0 - md_lo_q) : md_lo_q;
  assign rem_s  = md_neg_q ? (32'd0 - md_hi_q) : md_hi_q;

  always_comb begin
    md_result = '0;
    case (md_op_q)
      F3_MUL:                        md_result = prod_s[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  md_result = prod_s[63:32];
      // Unsigned division by zero already gives all ones; the signed case
      // would have the sign fix-up applied, so it is forced here.
      F3_DIV, F3_DIVU:               md_result = md_dz_q ? 32'hFFFF_FFFF : quot_s;
      default:                       md_result = rem_s;
    endcase
  end

  // Stall request: held while an M-op waits in IDLE or iterates in BUSY.
  assign md_busy = rst && m_op && (md_state_q == ST_IDLE || md_state_q == ST_BUSY);

  // ---------------------------------------------------------------------------
  // Next-state logic: keep > nop > normal
  // ---------------------------------------------------------------------------
  ex_mem_t normal_out;

  always_comb begin
    normal_out            = '0;
    normal_out.reg_write  = RegWrite_in;
    normal_out.memto_reg  = MemtoReg_in;
    normal_out.mem_rw     = MemRW_in;
    normal_out.mem_branch = MemBranch_in;
    normal_out.funct3     = funct3_in;
    normal_out.opcode     = opcode_in;
    normal_out.dsize      = funct3_in[1:0];
    // In DONE the M-op inputs are still held upstream, so only the data
    // field changes; the control fields come straight from decode.
    normal_out.alu_co     = (m_op && md_state_q == ST_DONE) ? md_result : alu_res;
    normal_out.read_data2 = rs2_in;
    normal_out.pc_branch  = PC_in + imm_in;
    normal_out.pc_p4      = PC_in + 32'd4;
    normal_out.wreg       = WReg_in;
    normal_out.instr      = Instr_in;
  end

  always_comb begin
    out_d      = out_q;
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    md_op_d    = md_op_q;
    md_neg_d   = md_neg_q;
    md_dz_d    = md_dz_q;
    md_b_d     = md_b_q;
    md_hi_d    = md_hi_q;
    md_lo_d    = md_lo_q;

    if (keep) begin
      // Everything holds, including during an M-op.
    end else if (nop) begin
      out_d      = '0;
      md_state_d = ST_IDLE;
      md_cnt_d   = '0;
    end else begin
      case (md_state_q)
        ST_IDLE: begin
          if (m_op) begin
            md_state_d = ST_BUSY;
            md_cnt_d   = '0;
            md_op_d    = funct3_in;
            md_neg_d   = (funct3_in == F3_REM) ? a_neg : (a_neg ^ b_neg);
            md_dz_d    = (funct3_in == F3_DIV) && (op_b == 32'd0);
            md_b_d     = b_mag;
            md_hi_d    = '0;
            md_lo_d    = a_mag;
          end
        end
        ST_BUSY: begin
          if (md_op_q[2]) begin
            md_hi_d = div_fits ? div_diff[31:0] : div_shift[31:0];
            md_lo_d = {md_lo_q[30:0], div_fits};
          end else begin
            md_hi_d = mul_sum[32:1];
            md_lo_d = {mul_sum[0], md_lo_q[31:1]};
          end
          md_cnt_d = md_cnt_q + 5'd1;
          if (md_cnt_q == 5'd31) md_state_d = ST_DONE;
        end
        ST_DONE: md_state_d = ST_IDLE;
        default: md_state_d = ST_IDLE;
      endcase
      out_d = md_busy ? ex_mem_t'('0) : normal_out;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      md_state_q <= ST_IDLE;
      md_cnt_q   <= '0;
      md_op_q    <= '0;
      md_neg_q   <= 1'b0;
      md_dz_q    <= 1'b0;
      md_b_q     <= '0;
      md_hi_q    <= '0;
      md_lo_q    <= '0;
    end else begin
      out_q      <= out_d;
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
      md_op_q    <= md_op_d;
      md_neg_q   <= md_neg_d;
      md_dz_q    <= md_dz_d;
      md_b_q     <= md_b_d;
      md_hi_q    <= md_hi_d;
      md_lo_q    <= md_lo_d;
    end
  end

  assign RegWrite_pype2    = out_q.reg_write;
  assign MemtoReg_pype2    = out_q.memto_reg;
  assign MemRW_pype2       = out_q.mem_rw;
  assign MemBranch_pype2   = out_q.mem_branch;
  assign funct3_pype2      = out_q.funct3;
  assign opcode_pype2      = out_q.opcode;
  assign dsize_pype2       = out_q.dsize;
  assign ALU_co_pype       = out_q.alu_co;
  assign read_data2_pype2  = out_q.read_data2;
  assign PCBranch_pype2    = out_q.pc_branch;
  assign PCp4_pype2        = out_q.pc_p4;
  assign WReg_pype2        = out_q.wreg;
  assign Instraction_pype2 = out_q.instr;

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port: clk  in  1  clock; all state updates on the rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: keep  in  1  global stall; holds all state.
REQ-004 SHALL have port: nop  in  1  flush; inserts a bubble.
REQ-005 SHALL have inputs from decode:
- RegWrite_in 1, MemtoReg_in 2, MemRW_in 2, MemBranch_in 3 (control).
- opcode_in 7, funct3_in 3, funct7_in 7.
- op_a 32, op_b 32 (forwarded ALU operands); rs2_in 32 (store data).
- imm_in 32, PC_in 32, WReg_in 5, Instr_in 32.
REQ-006 SHALL have registered outputs to the memory stage:
- RegWrite_pype2 1, MemtoReg_pype2 2, MemRW_pype2 2, MemBranch_pype2 3.
- funct3_pype2 3, opcode_pype2 7, dsize_pype2 2.
- ALU_co_pype 32, read_data2_pype2 32, PCBranch_pype2 32, PCp4_pype2 32.
- WReg_pype2 5, Instraction_pype2 32.
REQ-007 SHALL have output md_busy  out  1  (combinational); upstream stall request.

Function
REQ-008 SHALL compute the ALU result per RV32I: ADD/SUB, SLL/SRL/SRA (shamt = op_b[4:0]), SLT/SLTU, AND/OR/XOR; LUI passes op_b; loads/stores use op_a+op_b.
REQ-009 SHALL produce these ALU_co values for branches:
- BEQ/BNE: op_a-op_b.
- BLT/BGE: signed op_a<op_b ? 1 : 0.
- BLTU/BGEU: the unsigned equivalent.
REQ-010 SHALL produce for JALR: ALU_co = (op_a+imm_in) & 32'hFFFF_FFFE, and opcode_pype2 = 7'b1100111.
REQ-011 SHALL register PCBranch_pype2 = PC_in+imm_in and PCp4_pype2 = PC_in+4, both modulo 2^32.
REQ-012 SHALL register dsize_pype2 = {funct3_in[1],funct3_in[0]} (00 byte, 01 half, 10 word) and read_data2_pype2 = rs2_in.
REQ-013 SHALL treat opcode 0110011 with funct7 0000001 as M-extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), executed iteratively.
REQ-014 SHALL run the M-extension FSM with states IDLE, BUSY and DONE:
- IDLE→BUSY: M-op present, keep=0, nop=0; operands latched, counter cleared to 0.
- BUSY: one shift-add or restoring-divide step per cycle; after the count-31 step → DONE.
- DONE→IDLE on the next edge.
REQ-015 SHALL drive md_busy = 1 when an M-op is present and the state is IDLE or BUSY; md_busy = 0 in DONE.
REQ-016 SHALL keep md_busy high for exactly 33 cycles per M-op; the result is registered on the DONE edge, 34 edges after the M-op is first presented.
REQ-017 SHALL load a bubble (all control outputs 0) into the output register on every edge while md_busy=1.
REQ-018 SHALL use the decode inputs of the M-op (held upstream) for the control fields on the DONE edge.
REQ-019 SHALL handle divide by zero: quotient = 32'hFFFF_FFFF, remainder = dividend.
REQ-020 SHALL handle signed overflow (32'h8000_0000 / -1): quotient = 32'h8000_0000, remainder = 0.
REQ-021 SHALL apply priority keep > nop > normal.
REQ-022 SHALL, with keep=1, hold all output registers, the FSM state and the counter, regardless of nop.
REQ-023 SHALL, with nop=1 and keep=0, zero all output registers and force the FSM to IDLE, aborting any M-op in progress.
REQ-024 SHALL produce no X on outputs for any defined opcode; undefined opcodes yield ALU_co = 0 and propagate the control inputs unchanged.

Reset
REQ-025 SHALL, while rst=0, asynchronously clear all output registers to 0, set the FSM to IDLE, clear the counter to 0 and drive md_busy=0.
REQ-026 SHALL, on reset mid M-op, discard the operation; the first edge after release behaves as IDLE.

Verification
REQ-027 SHALL cover: ADD op_a=5, op_b=-7 → next edge ALU_co_pype=32'hFFFF_FFFE, PCp4_pype2=PC_in+4.
REQ-028 SHALL cover: BLT op_a=-1, op_b=0 → ALU_co_pype=1, MemBranch_pype2 equals input; BGEU with the same operands → ALU_co_pype=0.
REQ-029 SHALL cover: MUL 32'h0001_0000 × 32'h0001_0000 → md_busy high 33 cycles, bubbles output, then ALU_co_pype=0; MULHU of the same operands → 1.
REQ-030 SHALL cover: DIV 7 / 0 → 32'hFFFF_FFFF; REM 7 / 0 → 7; DIV 32'h8000_0000 / 32'hFFFF_FFFF → 32'h8000_0000.
REQ-031 SHALL cover: DIVU in BUSY, nop pulsed at cycle 10 → outputs zero, md_busy drops, FSM IDLE; the next ADD completes in 1 cycle.
REQ-032 SHALL cover: keep high for 5 cycles mid MUL → counter frozen, total latency 39 edges; rst low mid-op → outputs 0 immediately.
